// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch controller bus: divider ticks and debounced levels in,
// counter commands, blanking masks and mode out.
interface stopwatch_ctrl_if;
  logic       tick_1hz;
  logic       tick_2hz;
  logic       tick_blink;
  logic       pause_lvl;
  logic       adj_lvl;
  logic       sel_lvl;
  logic       clear_lvl;
  logic       cnt_inc;
  logic       inc_sec;
  logic       inc_min;
  logic       cnt_clr;
  logic       blank_min;
  logic       blank_sec;
  logic [1:0] mode;

  modport master (
    input  tick_1hz, tick_2hz, tick_blink,
    input  pause_lvl, adj_lvl, sel_lvl, clear_lvl,
    output cnt_inc, inc_sec, inc_min, cnt_clr,
    output blank_min, blank_sec, mode
  );

  modport slave (
    output tick_1hz, tick_2hz, tick_blink,
    output pause_lvl, adj_lvl, sel_lvl, clear_lvl,
    input  cnt_inc, inc_sec, inc_min, cnt_clr,
    input  blank_min, blank_sec, mode
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode controller: run/pause/adjust FSM, counter command
// pulses and adjust-mode blink masks, all outputs registered.
module stopwatch_ctrl #(
  parameter bit START_PAUSED = 1'b0,
  parameter bit BLINK_EN     = 1'b1
) (
  input  logic              clk_100mhz,
  input  logic              rst_n,
  stopwatch_ctrl_if.master  bus
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    PAUSED  = 2'b01,
    ADJ_SEC = 2'b10,
    ADJ_MIN = 2'b11
  } state_t;

  state_t state, state_nx;
  logic   saved_paused, saved_nx;
  logic   phase, phase_nx;
  logic   pause_q, clear_q;
  logic   pause_rise, clear_rise;
  logic   cnt_inc_q, inc_sec_q, inc_min_q, cnt_clr_q;
  logic   blank_min_q, blank_sec_q;

  assign pause_rise = bus.pause_lvl & ~pause_q;
  assign clear_rise = bus.clear_lvl & ~clear_q;

  always_comb begin
    state_nx = state;
    saved_nx = saved_paused;
    phase_nx = phase;
    unique case (state)
      RUN: begin
        if (bus.adj_lvl) begin
          state_nx = bus.sel_lvl ? ADJ_SEC : ADJ_MIN;
          saved_nx = 1'b0;
        end else if (pause_rise) begin
          state_nx = PAUSED;
        end
      end
      PAUSED: begin
        if (bus.adj_lvl) begin
          state_nx = bus.sel_lvl ? ADJ_SEC : ADJ_MIN;
          saved_nx = 1'b1;
        end else if (pause_rise) begin
          state_nx = RUN;
        end
      end
      default: begin
        if (!bus.adj_lvl)
          state_nx = saved_paused ? PAUSED : RUN;
        else
          state_nx = bus.sel_lvl ? ADJ_SEC : ADJ_MIN;
      end
    endcase
    // Entering adjust or swapping digit pair restarts blink visible
    if (state_nx[1] && state_nx != state)
      phase_nx = 1'b0;
    else if (state[1] && bus.tick_blink)
      phase_nx = ~phase;
  end

  always_ff @(posedge clk_100mhz) begin
    pause_q <= bus.pause_lvl;
    clear_q <= bus.clear_lvl;
    if (!rst_n) begin
      state        <= START_PAUSED ? PAUSED : RUN;
      saved_paused <= START_PAUSED;
      phase        <= 1'b0;
      cnt_inc_q    <= 1'b0;
      inc_sec_q    <= 1'b0;
      inc_min_q    <= 1'b0;
      cnt_clr_q    <= 1'b0;
      blank_min_q  <= 1'b0;
      blank_sec_q  <= 1'b0;
    end else begin
      state        <= state_nx;
      saved_paused <= saved_nx;
      phase        <= phase_nx;
      cnt_clr_q    <= clear_rise;
      cnt_inc_q    <= ~clear_rise & bus.tick_1hz & (state == RUN);
      inc_sec_q    <= ~clear_rise & bus.tick_2hz & (state == ADJ_SEC);
      inc_min_q    <= ~clear_rise & bus.tick_2hz & (state == ADJ_MIN);
      blank_sec_q  <= BLINK_EN & (state_nx == ADJ_SEC) & phase_nx;
      blank_min_q  <= BLINK_EN & (state_nx == ADJ_MIN) & phase_nx;
    end
  end

  assign bus.mode      = state;
  assign bus.cnt_inc   = cnt_inc_q;
  assign bus.inc_sec   = inc_sec_q;
  assign bus.inc_min   = inc_min_q;
  assign bus.cnt_clr   = cnt_clr_q;
  assign bus.blank_min = blank_min_q;
  assign bus.blank_sec = blank_sec_q;

endmodule
